// File: rtl/crossbar_pkg.sv
// Shared definitions for the 4x4 crossbar: port sizing, packet width,
// scheduler state encoding and sw_sel field slicing.
package crossbar_pkg;
  localparam int unsigned N_PORTS = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned PKT_W   = 15;
  localparam int unsigned SEL_W   = N_PORTS * IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Low bit of the index field for port p inside a packed sw_sel/req_dst vector.
  function automatic int unsigned sel_lo(input int unsigned p);
    return p * IDX_W;
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first set candidate at or above ptr,
// wrapping 3->0.
module rr_arbiter4
  import crossbar_pkg::*;
(
  input  logic [N_PORTS-1:0] cand,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               found
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xbar_sched.sv
// Round-robin scheduler for the 4x4 crossbar: arbitrates per output, starts
// the crossbar, waits for sw_ready (with timeout) and acks the winners.
module xbar_sched
  import crossbar_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PORTS-1:0] req_valid,
  input  logic [SEL_W-1:0]   req_dst,
  output logic [N_PORTS-1:0] req_ack,
  output logic               sw_start,
  output logic [SEL_W-1:0]   sw_sel,
  output logic [N_PORTS-1:0] sw_sel_vld,
  input  logic               sw_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt;
  logic [IDX_W-1:0]   rr_ptr [N_PORTS];
  logic [N_PORTS-1:0] cand   [N_PORTS];
  logic [IDX_W-1:0]   win    [N_PORTS];
  logic [N_PORTS-1:0] found;
  logic [SEL_W-1:0]   sel_d;
  logic [N_PORTS-1:0] won;
  logic               wait_expired;

  // cand[j] collects the inputs whose destination is output j.
  always_comb begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      cand[j] = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        cand[j][i] = req_valid[i] && (req_dst[sel_lo(i) +: IDX_W] == IDX_W'(j));
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_arb
    rr_arbiter4 u_arb (
      .cand  (cand[g]),
      .ptr   (rr_ptr[g]),
      .win   (win[g]),
      .found (found[g])
    );
  end

  always_comb begin
    sel_d = '0;
    won   = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      sel_d[sel_lo(j) +: IDX_W] = found[j] ? win[j] : '0;
      if (sw_sel_vld[j]) won[sw_sel[sel_lo(j) +: IDX_W]] = 1'b1;
    end
  end

  assign wait_expired = (state_q == ST_WAIT) && !sw_ready &&
                        (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|req_valid) state_d = ST_ARB;
      ST_ARB:   state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (sw_ready)          state_d = ST_DONE;
        else if (wait_expired) state_d = ST_IDLE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the transition being taken, so each one is
  // valid in the same cycle as the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ack     <= '0;
      sw_start    <= 1'b0;
      sw_sel      <= '0;
      sw_sel_vld  <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
      for (int unsigned j = 0; j < N_PORTS; j++) rr_ptr[j] <= '0;
    end else begin
      sw_start <= (state_q == ST_ARB);
      req_ack  <= (state_q == ST_WAIT && sw_ready) ? won : '0;
      busy     <= (state_d != ST_IDLE);

      if (state_q == ST_ARB) begin
        sw_sel     <= sel_d;
        sw_sel_vld <= found;
      end else if (state_q == ST_DONE || wait_expired) begin
        sw_sel_vld <= '0;
      end

      if (state_q == ST_ISSUE)                 wait_cnt <= '0;
      else if (state_q == ST_WAIT && !sw_ready) wait_cnt <= wait_cnt + 1'b1;

      if (wait_expired) timeout_err <= 1'b1;

      if (state_q == ST_DONE) begin
        for (int unsigned j = 0; j < N_PORTS; j++) begin
          if (sw_sel_vld[j]) rr_ptr[j] <= sw_sel[sel_lo(j) +: IDX_W] + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_sched.sv
// Self-checking bench for xbar_sched: directed scenarios plus randomized
// rounds against a round-robin reference model.
module tb_xbar_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_dst;
  logic [3:0] req_ack;
  logic       sw_start;
  logic [7:0] sw_sel;
  logic [3:0] sw_sel_vld;
  logic       sw_ready;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  int mptr [4];

  int         r_start_n, r_ack_n, r_end_n, r_ack_cnt;
  bit         r_expired;
  logic [7:0] r_sel;
  logic [3:0] r_vld, r_ack;

  xbar_sched #(.WAIT_MAX(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_dst     (req_dst),
    .req_ack     (req_ack),
    .sw_start    (sw_start),
    .sw_sel      (sw_sel),
    .sw_sel_vld  (sw_sel_vld),
    .sw_ready    (sw_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Reference: for output j the winner is the requesting input closest to
  // mptr[j] going upward in circular order.
  function automatic void model(input logic [3:0] v, input logic [7:0] d,
                                output logic [7:0] sel, output logic [3:0] vld,
                                output logic [3:0] ack);
    sel = '0; vld = '0; ack = '0;
    for (int j = 0; j < 4; j++) begin
      int best, bestd;
      best = -1; bestd = 99;
      for (int i = 0; i < 4; i++) begin
        if (v[i] && d[2*i +: 2] == j) begin
          if ((i - mptr[j] + 4) % 4 < bestd) begin
            bestd = (i - mptr[j] + 4) % 4;
            best  = i;
          end
        end
      end
      if (best >= 0) begin
        sel[2*j +: 2] = 2'(best);
        vld[j] = 1'b1;
        ack[best] = 1'b1;
      end
    end
  endfunction

  function automatic void model_commit(input logic [7:0] sel, input logic [3:0] vld);
    for (int j = 0; j < 4; j++)
      if (vld[j]) mptr[j] = (int'(sel[2*j +: 2]) + 1) % 4;
  endfunction

  // Drives one request from an IDLE DUT and records what happens. w is the
  // WAIT cycle index in which sw_ready is first high (-1: never); pulse puts
  // a sw_ready pulse in the ISSUE cycle, which must be ignored.
  task automatic run_round(input logic [3:0] v, input logic [7:0] d,
                           input int w, input bit pulse);
    bit seen_start;
    r_start_n = -1; r_ack_n = -1; r_end_n = -1; r_ack_cnt = 0;
    r_sel = '0; r_vld = '0; r_ack = '0; r_expired = 0;
    seen_start = 0;
    req_valid = v; req_dst = d; sw_ready = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (req_ack != 4'b0000) begin
        r_ack_cnt++;
        if (r_ack_n < 0) begin r_ack_n = n; r_ack = req_ack; end
      end
      if (sw_start && !seen_start) begin
        seen_start = 1; r_start_n = n; r_sel = sw_sel; r_vld = sw_sel_vld;
        sw_ready = pulse;
      end else if (seen_start) begin
        sw_ready = (r_ack_n < 0 && w >= 0 && n >= r_start_n + 1 + w);
      end
      if (seen_start && !busy) begin r_end_n = n; break; end
    end
    if (r_end_n < 0) r_expired = 1;
    sw_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; req_dst = '0; sw_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ack, sw_start, sw_sel, sw_sel_vld, busy, timeout_err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {req_ack, sw_start, sw_sel, sw_sel_vld, busy, timeout_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_ptr_out3;
    logic [7:0] es; logic [3:0] ev, ea;
    logic [3:0] want [2];
    want[0] = 4'b0001; want[1] = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      model(4'b0101, 8'h33, es, ev, ea);
      run_round(4'b0101, 8'h33, 0, 0);
      checks++;
      if (r_expired) begin errors++; $display("FAIL out3_round%0d no completion", r); end
      checks++;
      if (r_ack !== want[r] || r_ack !== ea) begin
        errors++; $display("FAIL out3_ack%0d got %b want %b", r, r_ack, want[r]);
      end
      checks++;
      if (r_sel !== es || r_vld !== 4'b1000) begin
        errors++; $display("FAIL out3_sel%0d got %h/%b want %h/1000", r, r_sel, r_vld, es);
      end
      model_commit(es, ev);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] es; logic [3:0] ev, ea;
    logic [3:0] want [5];
    want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
    want[3] = 4'b1000; want[4] = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      model(4'b1111, 8'h55, es, ev, ea);
      run_round(4'b1111, 8'h55, 0, 0);
      checks++;
      if (r_ack !== want[r] || r_ack !== ea || r_vld !== 4'b0010) begin
        errors++; $display("FAIL b2b_ack%0d got %b/%b want %b/0010", r, r_ack, r_vld, want[r]);
      end
      checks++;
      if (r_end_n !== 5) begin errors++; $display("FAIL b2b_len%0d got %0d want 5", r, r_end_n); end
      model_commit(es, ev);
    end
    req_valid = '0;
  endtask

  task automatic test_single;
    logic [7:0] es; logic [3:0] ev, ea;
    model(4'b0001, 8'h02, es, ev, ea);
    run_round(4'b0001, 8'h02, 0, 0);
    checks++;
    if (r_start_n !== 2) begin errors++; $display("FAIL single_start got %0d want 2", r_start_n); end
    checks++;
    if (r_sel[5:4] !== 2'd0 || r_vld !== 4'b0100) begin
      errors++; $display("FAIL single_sel got %h/%b want sel[5:4]=0/0100", r_sel, r_vld);
    end
    checks++;
    if (r_ack !== 4'b0001 || r_ack_n !== 4 || r_ack_cnt !== 1) begin
      errors++; $display("FAIL single_ack got %b@%0d x%0d want 0001@4 x1", r_ack, r_ack_n, r_ack_cnt);
    end
    model_commit(es, ev);
    // A sw_ready pulse during ISSUE must not end the round early.
    model(4'b0001, 8'h02, es, ev, ea);
    run_round(4'b0001, 8'h02, 2, 1);
    checks++;
    if (r_ack !== 4'b0001 || r_ack_n !== 6 || r_end_n !== 7) begin
      errors++; $display("FAIL issue_ready got %b@%0d end %0d want 0001@6 end 7", r_ack, r_ack_n, r_end_n);
    end
    model_commit(es, ev);
    req_valid = '0;
  endtask

  task automatic test_perm;
    logic [7:0] es; logic [3:0] ev, ea;
    model(4'b1111, 8'b00_01_10_11, es, ev, ea);
    run_round(4'b1111, 8'b00_01_10_11, 0, 0);
    checks++;
    if (r_sel !== 8'h1B || r_vld !== 4'b1111 || r_ack !== 4'b1111 || es !== 8'h1B) begin
      errors++; $display("FAIL perm got sel %h vld %b ack %b want 1b/1111/1111", r_sel, r_vld, r_ack);
    end
    model_commit(es, ev);
    req_valid = '0;
  endtask

  task automatic test_random;
    logic [7:0] es; logic [3:0] ev, ea;
    logic [3:0] v; logic [7:0] d; int w; bit p;
    for (int r = 0; r < 24; r++) begin
      v = 4'($urandom_range(1, 15));
      d = 8'($urandom);
      w = int'($urandom_range(0, 3));
      p = 1'($urandom_range(0, 1));
      model(v, d, es, ev, ea);
      run_round(v, d, w, p);
      checks++;
      if (r_sel !== es || r_vld !== ev) begin
        errors++; $display("FAIL rand%0d_sel got %h/%b want %h/%b", r, r_sel, r_vld, es, ev);
      end
      checks++;
      if (r_ack !== ea || r_ack_cnt !== 1) begin
        errors++; $display("FAIL rand%0d_ack got %b x%0d want %b x1", r, r_ack, r_ack_cnt, ea);
      end
      checks++;
      if (r_start_n !== 2 || r_ack_n !== 4 + w || r_end_n !== 5 + w) begin
        errors++; $display("FAIL rand%0d_timing got %0d/%0d/%0d want 2/%0d/%0d",
                           r, r_start_n, r_ack_n, r_end_n, 4 + w, 5 + w);
      end
      model_commit(es, ev);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout;
    logic [7:0] es; logic [3:0] ev, ea;
    model(4'b0001, 8'h00, es, ev, ea);
    run_round(4'b0001, 8'h00, -1, 0);
    checks++;
    if (r_start_n !== 2 || r_vld !== 4'b0001) begin
      errors++; $display("FAIL tmo_start got %0d/%b want 2/0001", r_start_n, r_vld);
    end
    checks++;
    if (r_end_n !== 19 || r_ack_cnt !== 0) begin
      errors++; $display("FAIL tmo_abort got end %0d acks %0d want 19/0", r_end_n, r_ack_cnt);
    end
    checks++;
    if (timeout_err !== 1'b1 || sw_sel_vld !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_flags got err %b vld %b busy %b want 1/0000/0",
                         timeout_err, sw_sel_vld, busy);
    end
    run_round(4'b0001, 8'h00, 0, 0);
    checks++;
    if (r_ack !== ea || r_sel !== es || r_vld !== ev || timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_retry got ack %b sel %h err %b want %b/%h/1",
                         r_ack, r_sel, timeout_err, ea, es);
    end
    model_commit(es, ev);
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 0;
    req_valid = 4'b0001; req_dst = 8'h00; sw_ready = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (sw_start) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_start got none want sw_start"); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_ack, sw_start, sw_sel, sw_sel_vld, busy, timeout_err} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0",
               {req_ack, sw_start, sw_sel, sw_sel_vld, busy, timeout_err});
    end
    @(negedge clk);
    req_valid = '0; rst = 1'b0;
    for (int j = 0; j < 4; j++) mptr[j] = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle busy got %b want 0", busy); end
    run_round(4'b0010, 8'h00, 0, 0);
    checks++;
    if (r_sel[1:0] !== 2'd1 || r_vld !== 4'b0001 || r_ack !== 4'b0010) begin
      errors++; $display("FAIL midrst_round got sel %h vld %b ack %b want sel[1:0]=1/0001/0010",
                         r_sel, r_vld, r_ack);
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_dst = '0; sw_ready = 1'b0;
    for (int j = 0; j < 4; j++) mptr[j] = 0;
    test_reset;
    test_ptr_out3;
    test_back_to_back;
    test_single;
    test_perm;
    test_random;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbar_sched.md
Name: xbar_sched

Overview:
- Round-robin scheduler for the 4x4 crossbar switch.
- Collects per-input transfer requests, each naming a destination output port, and resolves output contention with one round-robin arbiter per output.
- Drives the crossbar's start, per-output source-select and select-valid controls, waits for the crossbar's ready, then acknowledges the winning requesters.
- Sits between the input-port queues and the crossbar datapath.

Parameters:
- N_PORTS, 4, number of input and output ports; only 4 is supported.
- IDX_W, 2, width of a port index.
- WAIT_MAX, 16, number of WAIT cycles without sw_ready before the round is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  4  bit i: input i requests a transfer.
- req_dst  in  8  destination of input i at bits [2i+1:2i].
- req_ack  out  4  one-cycle pulse: input i's transfer completed.
- sw_start  out  1  one-cycle start pulse to the crossbar.
- sw_sel  out  8  source input index for output j at bits [2j+1:2j].
- sw_sel_vld  out  4  bit j: output j carries a granted transfer.
- sw_ready  in  1  crossbar completion indication.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set when a round is aborted; cleared only by rst.

Behaviour:
- Reset, asynchronous, applies at any time including mid-round:
  - all outputs go to 0 immediately;
  - all round-robin pointers (rr_ptr[j]) go to 0;
  - the wait counter goes to 0;
  - the state goes to IDLE.
- States: IDLE, ARB, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: go to ARB when |req_valid is 1; otherwise stay.
- ARB, 1 cycle:
  - For each output j, candidates are inputs i with req_valid[i]=1 and req_dst[i]=j.
  - The winner is the first candidate found searching upward from rr_ptr[j], wrapping 3->0.
  - Register sw_sel[j] = winner and sw_sel_vld[j] = 1 if any candidate exists. For outputs with no candidate, sw_sel[j]=0 and sw_sel_vld[j]=0.
  - Go to ISSUE.
- ISSUE, 1 cycle: sw_start=1; clear the wait counter; go to WAIT.
- WAIT:
  - sw_sel and sw_sel_vld are held stable; sw_start=0.
  - sw_ready is sampled from the first WAIT cycle only. A sw_ready high during ISSUE is ignored.
  - sw_ready=1: go to DONE.
  - Otherwise increment the wait counter. On the WAIT_MAX-th consecutive cycle without sw_ready: set timeout_err, clear sw_sel_vld, go to IDLE. No acks are issued and pointers are unchanged, so the next round re-grants the same winners.
- DONE, 1 cycle:
  - req_ack[i]=1 for each input i that won any output.
  - For every output j with sw_sel_vld[j]=1, set rr_ptr[j] = (winner+1) mod 4.
  - Clear sw_sel_vld; go to IDLE.
- Requester handshake:
  - req_valid and req_dst must stay stable from assertion until req_ack.
  - The requester may change or deassert them in the cycle after req_ack.
  - The scheduler samples requests only in ARB, so a request changed outside ARB is not an error.
- Latency: with request first seen in IDLE at cycle k and sw_ready=1 in the first WAIT cycle:
  - ARB at k+1;
  - sw_start at k+2;
  - WAIT at k+3;
  - req_ack at k+4;
  - IDLE at k+5.
  - Minimum round length is 5 cycles.
- Each input has one destination, so each input wins at most one output. Non-conflicting requests are all granted in the same round.
- sw_sel values are retained after a round and are meaningful only where sw_sel_vld=1.

Decomposition:
- Shared package crossbar_pkg holds:
  - N_PORTS, IDX_W and the crossbar packet width (15);
  - the state encoding for IDLE, ARB, ISSUE, WAIT, DONE;
  - the sw_sel field-slicing constants.
- Sub-module rr_arbiter4, instantiated once per output:
  - inputs: 4-bit candidate mask, 2-bit pointer;
  - outputs: 2-bit winner index, found flag;
  - purely combinational.

Test Plan:
- rst=1 during WAIT with sw_start history → all outputs 0 immediately; after release, busy=0 and the next single request to output 0 from input 1 yields sw_sel[1:0]=1.
- req_valid=0001, req_dst[1:0]=2, sw_ready=1 in first WAIT cycle → sw_start at k+2, sw_sel[5:4]=0, sw_sel_vld=0100, req_ack=0001 at k+4.
- req_dst=8'b00_01_10_11 (input 0→3, input 1→2, input 2→1, input 3→0), all valid → one round, sw_sel=8'h1B, sw_sel_vld=1111, req_ack=1111.
- All four inputs request output 1; each requester re-requests after its ack; sw_ready returned promptly → successive req_ack values 0001, 0010, 0100, 1000, 0001.
- req_valid=0001 to output 0, sw_ready held 0 → after 16 WAIT cycles timeout_err=1, sw_sel_vld=0, busy=0, no req_ack. Next round grants input 0 again, and timeout_err stays 1.
- Requests from inputs 0 and 2 to output 3 with rr_ptr[3]=0 after reset → first round grants input 0 and sets rr_ptr[3]=1; second round grants input 2.
